sym_fir_stream: RTL and testbench
=================================

Name: sym_fir_stream

Overview:
- Parametrised symmetric (linear-phase) FIR filter with an even number of taps, 2*HALF_TAPS.
- Only HALF_TAPS coefficients are stored. Each stored coefficient multiplies a pre-added pair of mirrored delay-line samples.
- One multiply-accumulate per clock, so a result takes HALF_TAPS cycles.
- Sits between a sample source and a sink using valid/ready handshakes on both sides. Coefficients are reloadable at run time through a daisy-chain shift port.

Parameters:
- DATA_W, 8: signed input sample width.
- COEF_W, 4: signed coefficient width.
- HALF_TAPS, 4: stored coefficients; total taps N = 2*HALF_TAPS; must be >= 2.
- OUT_W, 16: signed output width.
- Derived ACC_W = DATA_W + 1 + COEF_W + clog2(HALF_TAPS): full-precision accumulator width.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- s_valid, input, 1: input sample valid.
- s_ready, output, 1: block accepts a sample.
- s_data, input, DATA_W: signed input sample.
- coef_valid, input, 1: coefficient shift request.
- coef_ready, output, 1: block accepts a coefficient.
- coef_data, input, COEF_W: signed coefficient.
- m_valid, output, 1: output result valid.
- m_ready, input, 1: sink accepts the result.
- m_data, output, OUT_W: signed filter result.

Behaviour:
- Reset values:
  - State = IDLE.
  - Delay line buf[0..N-1] = 0.
  - coef[0..HALF_TAPS-1] = 1.
  - Accumulator and tap counter = 0.
  - m_valid = 0, m_data = 0.
- Reset takes effect at any point, including mid-MAC. The result in progress is discarded, with no m_valid pulse.
- States:
  - IDLE: waits for a sample or a coefficient.
  - MAC: runs the multiply-accumulate loop.
  - OUT: holds the result for the sink.
- Ready signals:
  - coef_ready = (state == IDLE).
  - s_ready = (state == IDLE) && !coef_valid. Coefficient load has priority when both are requested in the same cycle.
- Coefficient shift, in IDLE when coef_valid is high:
  - coef[0] <= coef_data, and coef[i] <= coef[i-1] for i >= 1.
  - State stays IDLE.
  - Sending c_a, c_b, ... leaves the last value sent in coef[0].
- Sample accept, in IDLE when s_valid && s_ready:
  - buf[0] <= s_data, and buf[i] <= buf[i-1].
  - acc <= 0, k <= 0, go to MAC.
- MAC, for k = 0..HALF_TAPS-1, one step per cycle:
  - acc <= acc + coef[k]*(buf[k] + buf[N-1-k]).
  - The pre-add is signed, DATA_W+1 bits. The product and sum are signed, in ACC_W bits, so the accumulator cannot overflow.
  - After the step with k == HALF_TAPS-1, go to OUT.
- OUT:
  - On entry, m_data is loaded from acc (see Optional Feature) and m_valid = 1.
  - m_data stays stable until m_valid && m_ready, then m_valid = 0 and the state returns to IDLE the next cycle.
  - s_ready and coef_ready are 0 throughout OUT (backpressure).
- Latency: a sample accepted at cycle t gives m_valid = 1 from cycle t+HALF_TAPS+1.
- Throughput: at most one sample per HALF_TAPS+2 cycles with m_ready tied high.
- m_data holds its last value after the handshake. It changes only on the next entry into OUT.
- The delay line persists across results. It is cleared only by reset; coefficient loads do not clear it.
- Effective impulse response:
  - h[k] = coef[k] for k < HALF_TAPS.
  - h[k] = coef[N-1-k] for k >= HALF_TAPS.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: m_data is acc saturated to the signed OUT_W range. Values above 2^(OUT_W-1)-1 clamp to that maximum; values below -2^(OUT_W-1) clamp to that minimum.
- Undefined: m_data = acc[OUT_W-1:0], which wraps.
- When OUT_W >= ACC_W, acc is sign-extended to OUT_W and both variants are identical.

Test Plan:
- Default coefficients, defaults for all parameters: send 1 followed by 9 zeros -> m_data sequence 1,1,1,1,1,1,1,1,0,0.
- Load coefficients 4,3,2,1 (giving coef = 1,2,3,4), then send 1 followed by 8 zeros -> m_data 1,2,3,4,4,3,2,1,0.
- Hold m_ready = 0 for 5 cycles after m_valid rises -> m_data stable, s_ready = 0 and coef_ready = 0 throughout; result consumed on the first cycle m_ready = 1.
- Assert s_valid and coef_valid together in IDLE -> coefficient shifts in, s_ready = 0, sample not taken; sample accepted the cycle after coef_valid drops.
- OUT_W = 8, all coefficients = 7, eight samples of 127 -> with FIR_SAT_EN, m_data = 127; without it, m_data = -56 (7112 mod 256).
- Assert reset during MAC -> next cycle m_valid = 0, s_ready = 1; following impulse gives the default-coefficient response, showing the delay line was cleared.

Source files
------------

// File: rtl/sym_fir_stream.sv
// Symmetric even-length FIR: pre-adds mirrored taps, one MAC per clock, valid/ready in and out.
// Define FIR_SAT_EN to saturate the result to OUT_W bits instead of wrapping.
module sym_fir_stream #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 4,
  parameter int HALF_TAPS = 4,
  parameter int OUT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_data
);

  localparam int N     = 2 * HALF_TAPS;
  localparam int K_W   = $clog2(HALF_TAPS);
  localparam int IDX_W = K_W + 1;
  localparam int ACC_W = DATA_W + 1 + COEF_W + K_W;

  localparam logic [K_W-1:0]   K_LAST   = K_W'(HALF_TAPS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [DATA_W-1:0] r_buf  [N];
  logic signed [COEF_W-1:0] r_coef [HALF_TAPS];
  logic signed [ACC_W-1:0]  r_acc;
  logic [K_W-1:0]           r_k;
  logic                     r_m_valid;
  logic signed [OUT_W-1:0]  r_m_data;

  logic                     w_accept;
  logic                     w_coef_shift;
  logic                     w_last;
  logic                     w_done;
  logic [IDX_W-1:0]         w_idx_near;
  logic [IDX_W-1:0]         w_idx_far;
  logic signed [DATA_W-1:0] w_near;
  logic signed [DATA_W-1:0] w_far;
  logic signed [DATA_W:0]   w_pre;
  logic signed [ACC_W-1:0]  w_pre_ext;
  logic signed [ACC_W-1:0]  w_coef_ext;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [OUT_W-1:0]  w_out;

  assign w_accept     = (r_state == IDLE) && s_valid && !coef_valid;
  assign w_coef_shift = (r_state == IDLE) && coef_valid;
  assign w_last       = (r_state == MAC) && (r_k == K_LAST);
  assign w_done       = (r_state == OUT) && m_ready;

  assign s_ready    = (r_state == IDLE) && !coef_valid;
  assign coef_ready = (r_state == IDLE);
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;

  // Tap k pairs with its mirror N-1-k; both are sign-extended before the pre-add.
  assign w_idx_near = {1'b0, r_k};
  assign w_idx_far  = IDX_LAST - w_idx_near;
  assign w_near     = r_buf[w_idx_near];
  assign w_far      = r_buf[w_idx_far];
  assign w_pre      = {w_near[DATA_W-1], w_near} + {w_far[DATA_W-1], w_far};
  assign w_pre_ext  = {{(ACC_W-DATA_W-1){w_pre[DATA_W]}}, w_pre};
  assign w_coef_ext = {{(ACC_W-COEF_W){r_coef[r_k][COEF_W-1]}}, r_coef[r_k]};
  assign w_prod     = w_pre_ext * w_coef_ext;
  assign w_acc_next = r_acc + w_prod;

  // The result register is loaded from the final sum in the same cycle acc takes it.
  generate
    if (OUT_W > ACC_W) begin : g_out_ext
      assign w_out = {{(OUT_W-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
    end else if (OUT_W == ACC_W) begin : g_out_eq
      assign w_out = w_acc_next;
    end else begin : g_out_narrow
`ifdef FIR_SAT_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        w_out = w_acc_next[OUT_W-1:0];
        if (w_acc_next > SAT_MAX) begin
          w_out = SAT_MAX[OUT_W-1:0];
        end else if (w_acc_next < SAT_MIN) begin
          w_out = SAT_MIN[OUT_W-1:0];
        end
      end
`else
      assign w_out = w_acc_next[OUT_W-1:0];
`endif
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = MAC;
      MAC:     if (r_k == K_LAST) w_state_next = OUT;
      OUT:     if (m_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_k       <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      for (int i = 0; i < HALF_TAPS; i++) r_coef[i] <= COEF_W'(1);
    end else begin
      r_state <= w_state_next;
      if (w_coef_shift) begin
        r_coef[0] <= coef_data;
        for (int i = 1; i < HALF_TAPS; i++) r_coef[i] <= r_coef[i-1];
      end
      if (w_accept) begin
        r_buf[0] <= s_data;
        for (int i = 1; i < N; i++) r_buf[i] <= r_buf[i-1];
        r_acc <= '0;
        r_k   <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= w_acc_next;
        r_k   <= r_k + K_W'(1);
      end
      if (w_last) begin
        r_m_data  <= w_out;
        r_m_valid <= 1'b1;
      end
      if (w_done) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sym_fir_stream.sv
// Randomised bench for sym_fir_stream: a 16-bit and an 8-bit output instance share one stimulus
// stream and are checked against a direct convolution model.
module tb_sym_fir_stream;

  localparam int H = 4;
  localparam int N = 2 * H;

  logic               clk;
  logic               reset;
  logic               s_valid;
  logic signed [7:0]  s_data;
  logic               coef_valid;
  logic signed [3:0]  coef_data;
  logic               m_ready;

  logic               s_ready_a, coef_ready_a, m_valid_a;
  logic signed [15:0] m_data_a;
  logic               s_ready_b, coef_ready_b, m_valid_b;
  logic signed [7:0]  m_data_b;

  int n_vec = 0;
  int n_bad = 0;
  int n_txn = 0;

  int mbuf  [N];
  int mcoef [H];

  sym_fir_stream #(.DATA_W(8), .COEF_W(4), .HALF_TAPS(H), .OUT_W(16)) u_dut_a (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .coef_valid(coef_valid), .coef_ready(coef_ready_a), .coef_data(coef_data),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a)
  );

  sym_fir_stream #(.DATA_W(8), .COEF_W(4), .HALF_TAPS(H), .OUT_W(8)) u_dut_b (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .coef_valid(coef_valid), .coef_ready(coef_ready_b), .coef_data(coef_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mbuf[i] = 0;
    for (int i = 0; i < H; i++) mcoef[i] = 1;
  endfunction

  function automatic void model_push(input int x);
    for (int i = N - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
    mbuf[0] = x;
  endfunction

  function automatic void model_coef(input int c);
    for (int i = H - 1; i > 0; i--) mcoef[i] = mcoef[i-1];
    mcoef[0] = c;
  endfunction

  // y[n] = sum_j h[j] * x[n-j], with the symmetric impulse response built from the stored half.
  function automatic int model_y();
    int s = 0;
    for (int j = 0; j < N; j++) begin
      int hj = (j < H) ? mcoef[j] : mcoef[N-1-j];
      s += hj * mbuf[j];
    end
    return s;
  endfunction

  function automatic int fit(input int v, input int w);
    int lim_hi = (1 << (w - 1)) - 1;
    int lim_lo = -(1 << (w - 1));
    int t;
`ifdef FIR_SAT_EN
    if (v > lim_hi) return lim_hi;
    if (v < lim_lo) return lim_lo;
    return v;
`else
    t = v <<< (32 - w);
    if (lim_hi < lim_lo) return 0;
    return t >>> (32 - w);
`endif
  endfunction

  // Entered one cycle after the sample was accepted.
  task automatic get_result(input int hold);
    int lat = 0;
    int exp_v, e16, e8;
    while (!m_valid_a && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, H);
    if (!m_valid_a) return;
    exp_v = model_y();
    e16 = fit(exp_v, 16);
    e8  = fit(exp_v, 8);
    check("m_data16", int'(m_data_a), e16);
    check("m_data8", int'(m_data_b), e8);
    check("m_valid8", int'(m_valid_b), 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_m_valid", int'(m_valid_a), 1);
      check("hold_m_data", int'(m_data_a), e16);
      check("hold_s_ready", int'(s_ready_a), 0);
      check("hold_coef_ready", int'(coef_ready_a), 0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("m_valid_clear", int'(m_valid_a), 0);
    check("m_data_keep", int'(m_data_a), e16);
    n_txn++;
    $display("txn %0d: x=%0d hold=%0d ref=%0d m16=%0d m8=%0d", n_txn, mbuf[0], hold, exp_v,
             int'(m_data_a), int'(m_data_b));
  endtask

  task automatic send(input int x, input int hold);
    s_data     = 8'(x);
    s_valid    = 1'b1;
    coef_valid = 1'b0;
    #1;
    check("s_ready", int'(s_ready_a), 1);
    tick();
    s_valid = 1'b0;
    model_push(x);
    get_result(hold);
  endtask

  task automatic load_coef(input int c);
    coef_data  = 4'(c);
    coef_valid = 1'b1;
    s_valid    = 1'b0;
    #1;
    check("coef_ready", int'(coef_ready_a), 1);
    tick();
    coef_valid = 1'b0;
    model_coef(c);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0;
    coef_valid = 1'b0; coef_data = '0; m_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_m_valid", int'(m_valid_a), 0);
    check("rst_m_data16", int'(m_data_a), 0);
    check("rst_m_data8", int'(m_data_b), 0);
    reset = 1'b0;
    #1;
    check("rst_s_ready", int'(s_ready_a), 1);
    check("rst_coef_ready", int'(coef_ready_a), 1);

    // Impulse with default coefficients.
    send(1, 0);
    for (int i = 0; i < 9; i++) send(0, 0);

    // Coefficients 4,3,2,1 leave coef = 1,2,3,4.
    load_coef(4); load_coef(3); load_coef(2); load_coef(1);
    send(1, 0);
    for (int i = 0; i < 8; i++) send(0, 0);

    // Sink backpressure.
    send(int'($urandom_range(0, 255)) - 128, 5);

    // Coefficient and sample requested together: coefficient wins.
    s_data = 8'(37); s_valid = 1'b1; coef_data = 4'(-3); coef_valid = 1'b1;
    #1;
    check("coll_s_ready", int'(s_ready_a), 0);
    check("coll_coef_ready", int'(coef_ready_a), 1);
    tick();
    model_coef(-3);
    coef_valid = 1'b0;
    #1;
    check("coll_m_valid", int'(m_valid_a), 0);
    check("coll_s_ready_after", int'(s_ready_a), 1);
    tick();
    s_valid = 1'b0;
    model_push(37);
    get_result(0);

    // Large positive sum for the 8-bit instance: 8 * 7 * 127 = 7112.
    for (int i = 0; i < H; i++) load_coef(7);
    for (int i = 0; i < N; i++) send(127, 0);
    check("big_ref", model_y(), 7112);

    // Random coefficients and samples.
    for (int i = 0; i < H; i++) load_coef(int'($urandom_range(0, 15)) - 8);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 5) == 0) load_coef(int'($urandom_range(0, 15)) - 8);
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)));
    end

    // Reset mid-MAC discards the result and clears the delay line.
    s_data = 8'(99); s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("mrst_m_valid", int'(m_valid_a), 0);
    check("mrst_s_ready", int'(s_ready_a), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrst_no_pulse", int'(m_valid_a), 0);
    end
    send(1, 0);
    for (int i = 0; i < 9; i++) send(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
